// File: rtl/lamp_conflict_monitor.sv
// Fail-safe lamp output stage placed after the T-intersection controller.
// Registers the six controller lamp signals and checks each sample for illegal
// combinations. Legal patterns are forwarded to the drivers and illegal ones are
// blocked. A conflict that persists for FILTER_CYCLES samples latches a fault
// and switches to flashing mode (main flashing yellow, side flashing red) until
// the operator gives a clear.
//
// Ports:
//   clk                                       system clock
//   reset                                     asynchronous, active-low reset
//   main_red_in/main_yellow_in/main_green_in  main-head lamps from the controller
//   side_red_in/side_yellow_in/side_green_in  side-head lamps from the controller
//   fault_clear                               operator clear, level-sensitive
//   main_red/main_yellow/main_green           main-head lamp drive, registered
//   side_red/side_yellow/side_green           side-head lamp drive, registered
//   fault                                     high while in FAULT
//   fault_code                                latched cause: [0] main invalid,
//                                             [1] side invalid, [2] cross conflict
module lamp_conflict_monitor #(
  parameter int FILTER_CYCLES     = 4,
  parameter int STARTUP_CYCLES    = 100_000_000,
  parameter int FLASH_HALF_PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       main_red_in,
  input  logic       main_yellow_in,
  input  logic       main_green_in,
  input  logic       side_red_in,
  input  logic       side_yellow_in,
  input  logic       side_green_in,
  input  logic       fault_clear,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int HW = (FLASH_HALF_PERIOD > 1) ? $clog2(FLASH_HALF_PERIOD) : 1;

  // Lamp vectors are ordered {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_PASS,
    ST_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      main_s, side_s;
  logic [2:0]      main_q, main_d;
  logic [2:0]      side_q, side_d;
  logic [FW-1:0]   filt_q, filt_d;
  logic [SW-1:0]   startup_q, startup_d;
  logic [HW-1:0]   flash_q, flash_d;
  logic            phase_q, phase_d;
  logic [2:0]      code_q, code_d;
  logic [2:0]      code_now;
  logic            illegal;
  logic            trigger;

  // Sample register. It resets to all-red so the first check after reset sees
  // a legal pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_s <= LAMP_RED;
      side_s <= LAMP_RED;
    end else begin
      main_s <= {main_red_in, main_yellow_in, main_green_in};
      side_s <= {side_red_in, side_yellow_in, side_green_in};
    end
  end

  always_comb begin
    code_now    = '0;
    code_now[0] = ($countones(main_s) != 1);
    code_now[1] = ($countones(side_s) != 1);
    code_now[2] = !main_s[2] && !side_s[2];
    illegal     = |code_now;
    trigger     = illegal && (filt_q == FW'(FILTER_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STARTUP;
      main_q    <= LAMP_RED;
      side_q    <= LAMP_RED;
      filt_q    <= '0;
      startup_q <= '0;
      flash_q   <= '0;
      phase_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      side_q    <= side_d;
      filt_q    <= filt_d;
      startup_q <= startup_d;
      flash_q   <= flash_d;
      phase_q   <= phase_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    side_d    = side_q;
    startup_d = startup_q;
    flash_d   = flash_q;
    phase_d   = phase_q;
    code_d    = code_q;

    // The filter saturates at FILTER_CYCLES. It can only get that high while
    // already in FAULT.
    if (!illegal)
      filt_d = '0;
    else if (filt_q != FW'(FILTER_CYCLES))
      filt_d = filt_q + 1'b1;
    else
      filt_d = filt_q;

    unique case (state_q)
      ST_STARTUP, ST_PASS: begin
        if (trigger) begin
          // Load the flash pattern on the entry edge so that the lamps change
          // in the same cycle that fault rises.
          state_d = ST_FAULT;
          code_d  = code_now;
          flash_d = '0;
          phase_d = 1'b1;
          main_d  = 3'b010;
          side_d  = LAMP_RED;
        end else if (state_q == ST_STARTUP) begin
          main_d = LAMP_RED;
          side_d = LAMP_RED;
          if (startup_q == SW'(STARTUP_CYCLES - 1)) begin
            state_d   = ST_PASS;
            startup_d = '0;
          end else begin
            startup_d = startup_q + 1'b1;
          end
        end else if (!illegal) begin
          main_d = main_s;
          side_d = side_s;
        end
      end

      ST_FAULT: begin
        if (fault_clear && !illegal) begin
          state_d   = ST_STARTUP;
          startup_d = '0;
          code_d    = '0;
          filt_d    = '0;
          main_d    = LAMP_RED;
          side_d    = LAMP_RED;
        end else begin
          if (flash_q == HW'(FLASH_HALF_PERIOD - 1)) begin
            flash_d = '0;
            phase_d = !phase_q;
          end else begin
            flash_d = flash_q + 1'b1;
          end
          main_d = {1'b0, phase_d, 1'b0};
          side_d = {phase_d, 2'b00};
        end
      end

      default: begin
        state_d = ST_STARTUP;
        main_d  = LAMP_RED;
        side_d  = LAMP_RED;
      end
    endcase
  end

  assign main_red    = main_q[2];
  assign main_yellow = main_q[1];
  assign main_green  = main_q[0];
  assign side_red    = side_q[2];
  assign side_yellow = side_q[1];
  assign side_green  = side_q[0];
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = code_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Testbench for lamp_conflict_monitor. Directed scenarios and a randomized run,
// checked against a cycle-level reference model of the lamp rules.
module tb_lamp_conflict_monitor;

  localparam int F = 4;
  localparam int S = 16;
  localparam int H = 8;

  // {main r,y,g, side r,y,g}
  localparam logic [5:0] ALLRED = 6'b100_100;
  localparam logic [5:0] MG_SR  = 6'b001_100;
  localparam logic [5:0] MY_SR  = 6'b010_100;
  localparam logic [5:0] MG_SG  = 6'b001_001;
  localparam logic [5:0] M0_SR  = 6'b000_100;
  localparam logic [5:0] FLASH1 = 6'b010_100;

  logic clk = 1'b0;
  logic reset;
  logic main_red_in, main_yellow_in, main_green_in;
  logic side_red_in, side_yellow_in, side_green_in;
  logic fault_clear;
  logic main_red, main_yellow, main_green;
  logic side_red, side_yellow, side_green;
  logic fault;
  logic [2:0] fault_code;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = all-red startup, 1 = pass, 2 = fault.
  logic [5:0] m_samp;
  logic [5:0] m_out;
  logic [2:0] m_code;
  int         m_mode;
  int         m_elapsed;
  int         m_run;
  int         m_t;

  always #5 clk = ~clk;

  lamp_conflict_monitor #(
    .FILTER_CYCLES(F),
    .STARTUP_CYCLES(S),
    .FLASH_HALF_PERIOD(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .main_red_in(main_red_in),
    .main_yellow_in(main_yellow_in),
    .main_green_in(main_green_in),
    .side_red_in(side_red_in),
    .side_yellow_in(side_yellow_in),
    .side_green_in(side_green_in),
    .fault_clear(fault_clear),
    .main_red(main_red),
    .main_yellow(main_yellow),
    .main_green(main_green),
    .side_red(side_red),
    .side_yellow(side_yellow),
    .side_green(side_green),
    .fault(fault),
    .fault_code(fault_code)
  );

  function automatic logic [5:0] lamps();
    return {main_red, main_yellow, main_green, side_red, side_yellow, side_green};
  endfunction

  function automatic logic [5:0] inputs();
    return {main_red_in, main_yellow_in, main_green_in,
            side_red_in, side_yellow_in, side_green_in};
  endfunction

  function automatic logic [2:0] bits_of(input logic [5:0] v);
    logic [2:0] b;
    logic [2:0] mh;
    logic [2:0] sh;
    mh   = v[5:3];
    sh   = v[2:0];
    b[0] = (int'(mh[0]) + int'(mh[1]) + int'(mh[2])) != 1;
    b[1] = (int'(sh[0]) + int'(sh[1]) + int'(sh[2])) != 1;
    b[2] = !v[5] && !v[2];
    return b;
  endfunction

  function automatic logic [5:0] flash_of(input int t);
    logic ph;
    ph = ((t / H) % 2) == 0;
    return {1'b0, ph, 1'b0, ph, 2'b00};
  endfunction

  task automatic set_in(input logic [5:0] v);
    {main_red_in, main_yellow_in, main_green_in,
     side_red_in, side_yellow_in, side_green_in} = v;
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_elapsed = 0;
    m_run     = 0;
    m_t       = 0;
    m_code    = '0;
    m_out     = ALLRED;
    m_samp    = ALLRED;
  endtask

  task automatic model_step();
    logic [2:0] b;
    logic       bad;
    logic       trig;
    if (!reset) begin
      model_reset();
      return;
    end
    b    = bits_of(m_samp);
    bad  = |b;
    trig = bad && (m_run == F - 1) && (m_mode != 2);
    if (trig) begin
      m_mode = 2;
      m_t    = 0;
      m_code = b;
      m_out  = flash_of(0);
    end else if (m_mode == 0) begin
      m_elapsed++;
      if (m_elapsed == S) m_mode = 1;
      m_out = ALLRED;
    end else if (m_mode == 1) begin
      if (!bad) m_out = m_samp;
    end else begin
      if (fault_clear && !bad) begin
        m_mode    = 0;
        m_elapsed = 0;
        m_code    = '0;
        m_out     = ALLRED;
      end else begin
        m_t++;
        m_out = flash_of(m_t);
      end
    end
    m_run  = bad ? m_run + 1 : 0;
    if (m_mode == 0 && m_elapsed == 0 && !bad) m_run = 0;
    m_samp = inputs();
  endtask

  // One clock: model advances on the edge, DUT is compared at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    checks++;
    if (lamps() !== m_out) begin
      failures++;
      $display("FAIL lamps: got %b expected %b at %0t", lamps(), m_out, $time);
    end
    checks++;
    if (fault !== (m_mode == 2)) begin
      failures++;
      $display("FAIL fault: got %b expected %b at %0t", fault, (m_mode == 2), $time);
    end
    checks++;
    if (fault_code !== m_code) begin
      failures++;
      $display("FAIL fault_code: got %b expected %b at %0t", fault_code, m_code, $time);
    end
  endtask

  task automatic expect_lamps(input string name, input logic [5:0] exp);
    checks++;
    if (lamps() !== exp) begin
      failures++;
      $display("FAIL %s: lamps got %b expected %b", name, lamps(), exp);
    end
  endtask

  task automatic expect_fault(input string name, input logic exp_f, input logic [2:0] exp_c);
    checks++;
    if (fault !== exp_f || fault_code !== exp_c) begin
      failures++;
      $display("FAIL %s: fault/code got %b/%b expected %b/%b", name, fault, fault_code, exp_f, exp_c);
    end
  endtask

  task automatic release_and_startup();
    set_in(MG_SR);
    fault_clear = 1'b0;
    reset = 1'b1;
    for (int i = 1; i <= S; i++) begin
      tick();
      if (i == 1 || i == S) expect_lamps("startup_allred", ALLRED);
    end
    tick();
    expect_lamps("startup_to_pass", MG_SR);
    expect_fault("startup_no_fault", 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fault_clear = 1'b0;
    set_in(MG_SR);
    model_reset();
    @(negedge clk);
    expect_lamps("reset_lamps", ALLRED);
    expect_fault("reset_fault", 1'b0, 3'b000);
    tick();
    tick();
  endtask

  task automatic test_startup();
    release_and_startup();
  endtask

  task automatic test_pass_latency();
    set_in(MY_SR);
    tick();
    expect_lamps("latency_k1", MG_SR);
    tick();
    expect_lamps("latency_k2", MY_SR);
    set_in(MG_SR);
    tick();
    tick();
    expect_lamps("latency_back", MG_SR);
  endtask

  task automatic test_transient();
    for (int rep = 0; rep < 2; rep++) begin
      set_in(MG_SG);
      for (int i = 0; i < 3; i++) begin
        tick();
        expect_lamps("transient_hold", MG_SR);
        expect_fault("transient_nofault", 1'b0, 3'b000);
      end
      set_in(MG_SR);
      tick();
      expect_lamps("transient_hold", MG_SR);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_fault("transient_filter_cleared", 1'b0, 3'b000);
    end
  endtask

  task automatic test_fault_entry();
    set_in(MG_SG);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_fault("entry_before", 1'b0, 3'b000);
    end
    tick();
    expect_fault("entry_k5", 1'b1, 3'b100);
    expect_lamps("entry_flash", FLASH1);
    for (int i = 6; i <= 21; i++) begin
      tick();
      expect_lamps("flash_phase", (i <= 12 || i == 21) ? FLASH1 : 6'b000_000);
    end
  endtask

  task automatic test_clear();
    fault_clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_fault("clear_ignored_illegal", 1'b1, 3'b100);
    end
    set_in(MG_SR);
    tick();
    expect_fault("clear_sample_lag", 1'b1, 3'b100);
    tick();
    expect_fault("clear_exit", 1'b0, 3'b000);
    expect_lamps("clear_allred", ALLRED);
    fault_clear = 1'b0;
    for (int i = 1; i <= S; i++) begin
      tick();
      if (i == S) expect_lamps("clear_startup_end", ALLRED);
    end
    tick();
    expect_lamps("clear_back_to_pass", MG_SR);
  endtask

  task automatic test_reset_in_fault();
    set_in(M0_SR);
    for (int i = 0; i < 5; i++) tick();
    expect_fault("main_dark_fault", 1'b1, 3'b001);
    for (int i = 0; i < 3; i++) tick();
    @(posedge clk);
    model_step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    expect_lamps("async_reset_lamps", ALLRED);
    expect_fault("async_reset_fault", 1'b0, 3'b000);
    @(negedge clk);
    tick();
    tick();
    release_and_startup();
  endtask

  task automatic test_random();
    logic [5:0] v;
    logic [5:0] burst_v;
    int         burst_left;
    int         r;
    burst_left = 0;
    burst_v    = MG_SG;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (burst_left > 0) begin
        v = burst_v;
        burst_left--;
      end else if (r < 8) begin
        do burst_v = 6'($urandom); while (bits_of(burst_v) == 3'b000);
        burst_left = $urandom_range(0, 6);
        v = burst_v;
      end else if (r < 12) begin
        v = 6'($urandom);
      end else begin
        do v = 6'($urandom); while (bits_of(v) != 3'b000);
      end
      set_in(v);
      fault_clear = ($urandom_range(0, 9) == 0);
      tick();
    end
    fault_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_pass_latency();
    test_transient();
    test_fault_entry();
    test_clear();
    test_reset_in_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lamp_conflict_monitor.md
Name: lamp_conflict_monitor

Overview:
- Fail-safe output stage directly downstream of the T-intersection traffic controller.
- Consumes the controller's six lamp signals and checks every cycle for illegal lamp combinations.
- Passes legal patterns to the lamp drivers.
- On a persistent conflict it latches a fault and drives the intersection into flashing mode: main road flashing yellow, side road flashing red. Flashing mode is held until an operator clear is given.

Parameters:
- FILTER_CYCLES, 4: consecutive illegal samples required to declare a fault (≥1).
- STARTUP_CYCLES, 100_000_000: length of the all-red period after reset or after a fault clear (≥1).
- FLASH_HALF_PERIOD, 25_000_000: cycles per flash phase (on or off) (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- main_red_in, main_yellow_in, main_green_in  in  1 each  main-head lamps from the controller
- side_red_in, side_yellow_in, side_green_in  in  1 each  side-head lamps from the controller
- fault_clear  in  1  operator clear, level-sensitive
- main_red, main_yellow, main_green  out  1 each  main-head lamp drive, registered
- side_red, side_yellow, side_green  out  1 each  side-head lamp drive, registered
- fault  out  1  high while in FAULT
- fault_code  out  3  latched cause: [0] main head invalid, [1] side head invalid, [2] cross conflict

Behaviour:
- Reset (reset=0, async):
  - state=STARTUP; all counters 0.
  - main_red=1, side_red=1, all other lamp outputs 0.
  - fault=0, fault_code=0.
- Input stage: all six inputs are registered once (sample register) before checking.
- Legality, evaluated on the sample register:
  - bit0 = main head does not have exactly one lamp on.
  - bit1 = side head does not have exactly one lamp on.
  - bit2 = main_red=0 and side_red=0 simultaneously.
  - A sample is illegal if any bit is set.
- Filter counter:
  - Increments on each illegal sample; clears to 0 on any legal sample.
  - Saturates; width is $clog2(FILTER_CYCLES+1).
- STARTUP:
  - Outputs forced all-red.
  - Startup counter counts STARTUP_CYCLES cycles, then moves to PASS.
  - Checking and filtering stay active; a filtered fault goes to FAULT and takes priority over startup expiry in the same cycle.
- PASS, legal sample: the outputs take the sample-register value. Latency is 2 cycles (a legal input at cycle k is on the outputs at cycle k+2).
- PASS, illegal sample: the outputs hold their previous value, so illegal patterns are never forwarded.
- Fault entry:
  - Trigger: the sample is illegal and the filter counter equals FILTER_CYCLES-1. This is reachable from STARTUP or PASS.
  - Next state is FAULT.
  - fault_code latches that sample's three bits.
  - fault rises exactly FILTER_CYCLES+1 cycles after the first illegal input cycle.
  - The lamp outputs switch to the flash pattern in the same cycle that fault rises.
- FAULT:
  - flash_phase starts at 1 on entry and toggles every FLASH_HALF_PERIOD cycles.
  - main_yellow=flash_phase, side_red=flash_phase; all other lamps 0.
  - fault=1; fault_code is held. Further illegal samples do not change fault_code.
- FAULT exit:
  - Condition: fault_clear=1 and the current sample is legal.
  - Next state is STARTUP: the startup counter restarts, outputs are all-red the next cycle, fault=0, fault_code=0, filter counter 0.
  - fault_clear with an illegal sample is ignored.
  - fault_clear has no effect in STARTUP or PASS.
- Reset asserted mid-operation, including during FAULT: immediately returns to reset values. The fault is not retained across reset.
- FILTER_CYCLES=1: a single illegal sample faults. fault rises 2 cycles after the illegal input.
- Flash counter width: $clog2(FLASH_HALF_PERIOD). Startup counter width: $clog2(STARTUP_CYCLES). Both wrap to 0 at terminal count.

Test Plan:
Bench parameters: FILTER_CYCLES=4, STARTUP_CYCLES=16, FLASH_HALF_PERIOD=8.
1. Release reset at cycle 0 with a legal main-green pattern → outputs all-red for cycles 1–16. From cycle 17: main_green=1, side_red=1, fault=0.
2. In PASS, change input to main_yellow=1/side_red=1 at cycle k → that pattern appears on the outputs at k+2.
3. In PASS, drive main_green=1 and side_green=1 (others 0) for 3 cycles, then a legal pattern → outputs hold the prior legal pattern throughout; fault stays 0; the filter counter returns to 0.
4. In PASS, hold main_green=1/side_green=1 (others 0) from cycle k → fault=1 at k+5 with fault_code=3'b100. main_yellow and side_red are 1 for 8 cycles, then 0 for 8 cycles, repeating; all other lamps 0.
5. In FAULT, assert fault_clear with the illegal input still present → no exit. Then apply a legal input with fault_clear=1 → all-red the next cycle, fault=0, fault_code=0, and PASS after 16 cycles.
6. In FAULT with main inputs all 0 (fault_code=3'b001), pull reset low mid-flash → the outputs immediately show main_red=1, side_red=1, fault=0, fault_code=0.
